// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button / switch conditioning block.
// Holds board timing constants, the per-channel debounce FSM encoding and
// a helper that sizes the stability counter.
package button_debouncer_pkg;

    localparam int CLK_HZ                = 100_000_000;
    localparam int DEBOUNCE_MS           = 10;
    localparam int DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef enum logic [1:0] {
        DB_STABLE_LO = 2'd0,
        DB_CHECK_HI  = 2'd1,
        DB_STABLE_HI = 2'd2,
        DB_CHECK_LO  = 2'd3
    } db_state_e;

    // The counter only ever holds 0..cycles-1, so clog2 bits suffice (min 1).
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounce channel: optional polarity inversion, metastability flop
// chain, stability-check FSM with counter, and registered level / rise /
// fall / toggle outputs.
// Ports:
//   clk         in  clock
//   rst         in  synchronous active-high reset
//   pin_i       in  raw asynchronous pin level
//   level_o     out debounced active-high level
//   rise_o      out one-cycle pulse on accepted 0->1
//   fall_o      out one-cycle pulse on accepted 1->0
//   toggle_o    out flips on every accepted rise
//   rise_next_o out next-cycle value of rise_o, lets the parent register
//                   a reduction in the same cycle as rise_o
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o,
    output logic rise_next_o
);

    localparam int              CNT_W     = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    // With a one-sample requirement a change is accepted from the STABLE state.
    localparam bit               IMMEDIATE = (STABLE_CYCLES == 1);

    logic                   pin_pol;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             toggle_q, toggle_d;

    // Inversion sits ahead of the synchronizer so reset value 0 means "released".
    assign pin_pol = (ACTIVE_LOW != 0) ? ~pin_i : pin_i;
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], pin_pol};
    assign s       = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        toggle_d = toggle_q;
        case (state_q)
            DB_STABLE_LO: begin
                if (s) begin
                    if (IMMEDIATE) begin
                        state_d  = DB_STABLE_HI;
                        level_d  = 1'b1;
                        rise_d   = 1'b1;
                        toggle_d = ~toggle_q;
                    end else begin
                        state_d = DB_CHECK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            DB_CHECK_HI: begin
                if (!s) begin
                    state_d = DB_STABLE_LO;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = DB_STABLE_HI;
                    cnt_d    = CNT_ZERO;
                    level_d  = 1'b1;
                    rise_d   = 1'b1;
                    toggle_d = ~toggle_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DB_STABLE_HI: begin
                if (!s) begin
                    if (IMMEDIATE) begin
                        state_d = DB_STABLE_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = DB_CHECK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            DB_CHECK_LO: begin
                if (s) begin
                    state_d = DB_STABLE_HI;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_STABLE_LO;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_STABLE_LO;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= DB_STABLE_LO;
            cnt_q    <= CNT_ZERO;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
        end
    end

    assign level_o     = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign toggle_o    = toggle_q;
    assign rise_next_o = rise_d;

endmodule

// File: rtl/button_debouncer.sv
// Conditions raw board buttons/switches into clean synchronous levels,
// one-cycle press/release pulses and per-channel toggle flags.
// Ports:
//   clk        in  100 MHz board clock (sole domain)
//   rst        in  synchronous active-high reset
//   btn_in     in  [N_INPUTS] raw asynchronous pin levels
//   btn_level  out [N_INPUTS] debounced active-high level
//   btn_rise   out [N_INPUTS] one-cycle pulse on accepted press
//   btn_fall   out [N_INPUTS] one-cycle pulse on accepted release
//   btn_toggle out [N_INPUTS] flips on every press
//   any_press  out            OR of btn_rise, aligned with btn_rise
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int N_INPUTS      = 5,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INPUTS-1:0] btn_in,
    output logic [N_INPUTS-1:0] btn_level,
    output logic [N_INPUTS-1:0] btn_rise,
    output logic [N_INPUTS-1:0] btn_fall,
    output logic [N_INPUTS-1:0] btn_toggle,
    output logic                any_press
);

    logic [N_INPUTS-1:0] rise_next;
    logic                any_press_q, any_press_d;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_ch
        button_debouncer_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pin_i      (btn_in[g]),
            .level_o    (btn_level[g]),
            .rise_o     (btn_rise[g]),
            .fall_o     (btn_fall[g]),
            .toggle_o   (btn_toggle[g]),
            .rise_next_o(rise_next[g])
        );
    end

    // Reduce the channels' next-rise values so any_press lands in the same
    // cycle as btn_rise while still coming straight from a flop.
    assign any_press_d = |rise_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: two instances (active-high pins and
// active-low pins fed inverted stimulus) checked every cycle against a
// window-based reference model through a scoreboard queue.
module tb_button_debouncer;

    localparam int N      = 2;
    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] toggle;
        logic         any;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] btn_n;

    logic [N-1:0] lvl0, rise0, fall0, tog0;
    logic         any0;
    logic [N-1:0] lvl1, rise1, fall1, tog1;
    logic         any1;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    bit   stim_done = 1'b0;

    assign btn_n = ~btn;

    always #5 clk = ~clk;

    button_debouncer #(
        .N_INPUTS(N), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .rst(rst), .btn_in(btn),
        .btn_level(lvl0), .btn_rise(rise0), .btn_fall(fall0),
        .btn_toggle(tog0), .any_press(any0)
    );

    button_debouncer #(
        .N_INPUTS(N), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .rst(rst), .btn_in(btn_n),
        .btn_level(lvl1), .btn_rise(rise1), .btn_fall(fall1),
        .btn_toggle(tog1), .any_press(any1)
    );

    // Reference model: a channel's level flips once the last STABLE samples
    // seen after the synchronizer delay all disagree with the current level.
    initial begin : predictor
        logic [31:0]  hist [N];
        logic [N-1:0] m_level;
        logic [N-1:0] m_tog;
        logic [31:0]  win;
        logic [31:0]  mask;
        exp_t         e;
        mask    = (32'd1 << STABLE) - 32'd1;
        m_level = '0;
        m_tog   = '0;
        for (int c = 0; c < N; c++) hist[c] = '0;
        forever begin
            @(posedge clk);
            e = '0;
            if (rst) begin
                for (int c = 0; c < N; c++) hist[c] = '0;
                m_level = '0;
                m_tog   = '0;
            end else begin
                for (int c = 0; c < N; c++) begin
                    hist[c] = {hist[c][30:0], btn[c]};
                    win     = (hist[c] >> SYNC) & mask;
                    if (!m_level[c] && win == mask) begin
                        m_level[c] = 1'b1;
                        m_tog[c]   = ~m_tog[c];
                        e.rise[c]  = 1'b1;
                    end else if (m_level[c] && win == 32'd0) begin
                        m_level[c] = 1'b0;
                        e.fall[c]  = 1'b1;
                    end
                end
            end
            e.level  = m_level;
            e.toggle = m_tog;
            e.any    = |e.rise;
            sb_q.push_back(e);
        end
    end

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got lvl=%b rise=%b fall=%b tog=%b any=%b want lvl=%b rise=%b fall=%b tog=%b any=%b",
                     name, cyc, got.level, got.rise, got.fall, got.toggle, got.any,
                     want.level, want.rise, want.fall, want.toggle, want.any);
        end
    endtask

    initial begin : monitor
        exp_t want;
        exp_t got0;
        exp_t got1;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb_q.size() > 0) begin
                want = sb_q.pop_front();
                got0 = '{level: lvl0, rise: rise0, fall: fall0, toggle: tog0, any: any0};
                got1 = '{level: lvl1, rise: rise1, fall: fall1, toggle: tog1, any: any1};
                check("active_high", got0, want);
                check("active_low",  got1, want);
            end
        end
    end

    task automatic step(input logic [N-1:0] b, input logic r);
        @(negedge clk);
        btn = b;
        rst = r;
    endtask

    task automatic hold(input logic [N-1:0] b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin : stimulus
        logic [8:0] bounce;
        logic [N-1:0] cur;
        bounce = 9'b111101101;
        // Reset with both pins pressed, then release reset.
        for (int i = 0; i < 3; i++) step(2'b11, 1'b1);
        hold(2'b11, 8);
        hold(2'b00, 8);
        // Clean press and release on channel 0.
        hold(2'b01, 8);
        hold(2'b00, 8);
        // Short glitch (3) rejected, then 4-sample pulse accepted.
        hold(2'b01, 3);
        hold(2'b00, 8);
        hold(2'b01, 4);
        hold(2'b00, 8);
        // Bounce on channel 1 (LSB first: 1,0,1,1,0,1,1,1,1), then release.
        for (int i = 0; i < 9; i++) step({bounce[i], 1'b0}, 1'b0);
        hold(2'b10, 4);
        hold(2'b00, 8);
        // Three presses on ch0 interleaved with one on ch1.
        hold(2'b01, 6); hold(2'b00, 6);
        hold(2'b10, 6); hold(2'b00, 6);
        hold(2'b01, 6); hold(2'b00, 6);
        hold(2'b01, 6); hold(2'b00, 6);
        // Simultaneous press.
        hold(2'b11, 8);
        hold(2'b00, 8);
        // Reset while ch0 is mid-check (cnt=2), pin held through reset.
        hold(2'b01, 4);
        step(2'b01, 1'b1);
        hold(2'b01, 8);
        hold(2'b00, 8);
        // Randomized bouncing with occasional resets.
        cur = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 30) cur = N'($urandom_range(0, (1 << N) - 1));
            step(cur, ($urandom_range(0, 199) == 0));
            if ($urandom_range(0, 19) == 0) hold(cur, STABLE + SYNC + 1);
        end
        hold(2'b00, 10);
        stim_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
